pulse_bank: RTL
===============

PULSE_BANK -- requirements
Module: pulse_bank

Interface
REQ-001 Parameter N_CH, default 2, number of pulse voices, legal range 1..4.
REQ-002 Parameter CW, default 1, channel-select width, equal to max(1, clog2(N_CH)).
REQ-003 Parameter MW, default 4+CW, mix output width.
REQ-004 apu_clk  in  1  sole clock; every register updates on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 tick_en  in  1  one-cycle APU timer tick strobe.
REQ-007 qtr_en  in  1  quarter-frame strobe; clocks the envelopes.
REQ-008 hlf_en  in  1  half-frame strobe; clocks the length counters and sweeps.
REQ-009 wr_en  in  1  register write strobe.
REQ-010 wr_addr  in  CW+2  write address: [CW+1:2] selects the channel, [1:0] selects r0..r3.
REQ-011 wr_data  in  8  write data.
REQ-012 ch_enable  in  N_CH  per-channel enable.
REQ-013 len_active  out  N_CH  bit set when that channel's length counter is non-zero.
REQ-014 ch_out  out  4*N_CH  per-channel volume; channel k occupies [4k+3:4k].
REQ-015 mix_out  out  MW  unsigned sum of all ch_out.

Function
REQ-016 Each channel holds r0..r3; r0 = {duty[1:0], halt/loop, const, vol/P[3:0]}; r1 = {sw_en, sw_P[2:0], neg, shift[2:0]}; period[10:0] = {r3[2:0], r2}; len_idx = r3[7:3].
REQ-017 A write with a channel select >= N_CH is ignored.
REQ-018 Write to r3: load length from LUT[len_idx] only if ch_enable=1, reset the sequencer index to 0, and set the envelope start flag.
REQ-019 Length LUT (32 entries): 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
REQ-020 Write to r1 sets the sweep reload flag.
REQ-021 Timer (11-bit) on tick_en: if timer==0, reload period and increment the sequencer index (7 wraps to 0); otherwise decrement.
REQ-022 Sequencer bit = pattern[7-idx]; patterns are duty0 01000000, duty1 01100000, duty2 01111000, duty3 10011111.
REQ-023 Envelope on qtr_en, when the start flag is set: clear the flag, decay=15, divider=P.
REQ-024 Envelope on qtr_en, otherwise: if divider==0, divider=P, then decrement decay if non-zero, else reload decay to 15 if loop=1; if divider!=0, decrement divider.
REQ-025 Volume = P when const=1, otherwise decay.
REQ-026 Length on hlf_en: decrement when non-zero and halt=0; hold at 0.
REQ-027 ch_enable=0 forces length to 0 on the same edge, with priority over any r3 write.
REQ-028 An r3 load on the same edge as a hlf_en decrement: the load wins.
REQ-029 Sweep change = period >> shift, computed in 12 bits.
REQ-030 Sweep target = period + change when neg=0.
REQ-031 Sweep target with neg=1: channel 0 uses period - change - 1 (ones' complement); every other channel uses period - change.
REQ-032 mute = (period < 8) or (target > 2047); mute is evaluated continuously.
REQ-033 Sweep on hlf_en: if divider==0, sw_en=1, shift!=0 and mute=0, write target[10:0] into r2/r3[2:0].
REQ-034 Sweep on hlf_en, divider update: if divider==0 or reload=1, divider=sw_P and reload clears; otherwise divider decrements.
REQ-035 A CPU write to r2/r3 on the same edge as a sweep update: the CPU write wins.
REQ-036 ch_out = 0 when mute=1, length==0 or the sequencer bit is 0; otherwise ch_out = volume.
REQ-037 ch_out and mix_out are registered: one cycle of latency from the internal state.
REQ-038 Simultaneous strobes on one edge are all applied, each to its own unit.

Reset
REQ-039 On rst_n=0 at a clock edge, all of the following clear to 0: registers, timers, sequencer index, envelope, sweep divider and flags, length, ch_out, mix_out, len_active.
REQ-040 Reset applied mid-operation discards any pending start or reload flag.
REQ-041 Strobes and writes are ignored while rst_n=0.

Verification
REQ-042 Length load/decrement: ch_enable=1; write r3=0x08 (len_idx 1) -> length=254; 254 hlf_en strobes with halt=0 -> len_active=0; ch_out=0 from the following cycle.
REQ-043 Duty and timer: duty2, period=8, const=1, vol=9, length loaded; apply tick_en continuously -> ch_out sequence 0,9,9,9,9,0,0,0, each value held for 9 ticks.
REQ-044 Envelope: r0=0x03 (loop=0, const=0, P=3), write r3 -> on qtr_en, volume 15 then decrements every 4 strobes to 0 and holds; with loop=1 it wraps from 0 back to 15.
REQ-045 Sweep negate modes: period=0x100, shift=1, neg=1, sw_P=0, sw_en=1 -> first hlf_en gives channel 0 period 0x07F and channel 1 period 0x080.
REQ-046 Mute: period=0x7F0, shift=1, neg=0 -> target 0xBE8 > 2047, ch_out=0 and period unchanged; period=5 -> ch_out=0 regardless of the sweep settings.
REQ-047 Reset and collision: assert rst_n=0 mid-note -> all outputs 0 on the next edge; separately, r3 write on the same edge as hlf_en -> the LUT value is loaded, not decremented.

Source files
------------

// File: rtl/pulse_bank.sv
// Bank of N_CH square-wave voices: per-voice timer, duty sequencer, envelope,
// length counter and sweep unit, with a registered per-voice volume and sum.
module pulse_bank_ch #(
  parameter int CH_IDX = 0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  input  logic       i_qtr,
  input  logic       i_hlf,
  input  logic       i_wr,
  input  logic [1:0] i_reg,
  input  logic [7:0] i_data,
  input  logic       i_en,
  output logic       o_len_active,
  output logic [3:0] o_vol_nxt,
  output logic [3:0] o_ch_out
);
  logic [7:0]  r_r0, r_r1, r_r2;
  logic [2:0]  r_per_hi;
  logic [10:0] r_timer;
  logic [2:0]  r_seq;
  logic        r_env_start;
  logic [3:0]  r_decay, r_env_div;
  logic [7:0]  r_len;
  logic [2:0]  r_sw_div;
  logic        r_sw_reload;
  logic [3:0]  r_ch_out;

  logic [10:0] w_period;
  logic [11:0] w_change, w_target;
  logic        w_mute, w_seq_bit, w_sw_upd;
  logic [7:0]  w_pat, w_lut;
  logic [3:0]  w_vol;
  logic        w_wr0, w_wr1, w_wr2, w_wr3;

  assign w_period = {r_per_hi, r_r2};
  assign w_change = {1'b0, w_period} >> r_r1[2:0];

  // Voice 0 negates in ones' complement, the others in two's complement.
  always_comb begin
    w_target = {1'b0, w_period} + w_change;
    if (r_r1[3]) begin
      if (CH_IDX == 0) w_target = {1'b0, w_period} - w_change - 12'd1;
      else             w_target = {1'b0, w_period} - w_change;
    end
  end

  assign w_mute = (w_period < 11'd8) || w_target[11];

  always_comb begin
    case (r_r0[7:6])
      2'd0:    w_pat = 8'b0100_0000;
      2'd1:    w_pat = 8'b0110_0000;
      2'd2:    w_pat = 8'b0111_1000;
      default: w_pat = 8'b1001_1111;
    endcase
  end

  always_comb begin
    case (i_data[7:3])
      5'd0:  w_lut = 8'd10;   5'd1:  w_lut = 8'd254;  5'd2:  w_lut = 8'd20;  5'd3:  w_lut = 8'd2;
      5'd4:  w_lut = 8'd40;   5'd5:  w_lut = 8'd4;    5'd6:  w_lut = 8'd80;  5'd7:  w_lut = 8'd6;
      5'd8:  w_lut = 8'd160;  5'd9:  w_lut = 8'd8;    5'd10: w_lut = 8'd60;  5'd11: w_lut = 8'd10;
      5'd12: w_lut = 8'd14;   5'd13: w_lut = 8'd12;   5'd14: w_lut = 8'd26;  5'd15: w_lut = 8'd14;
      5'd16: w_lut = 8'd12;   5'd17: w_lut = 8'd16;   5'd18: w_lut = 8'd24;  5'd19: w_lut = 8'd18;
      5'd20: w_lut = 8'd48;   5'd21: w_lut = 8'd20;   5'd22: w_lut = 8'd96;  5'd23: w_lut = 8'd22;
      5'd24: w_lut = 8'd192;  5'd25: w_lut = 8'd24;   5'd26: w_lut = 8'd72;  5'd27: w_lut = 8'd26;
      5'd28: w_lut = 8'd16;   5'd29: w_lut = 8'd28;   5'd30: w_lut = 8'd32;  default: w_lut = 8'd30;
    endcase
  end

  assign w_seq_bit    = w_pat[3'd7 - r_seq];
  assign w_vol        = r_r0[4] ? r_r0[3:0] : r_decay;
  assign o_vol_nxt    = (w_mute || (r_len == 8'd0) || !w_seq_bit) ? 4'd0 : w_vol;
  assign o_len_active = (r_len != 8'd0);
  assign o_ch_out     = r_ch_out;

  assign w_wr0 = i_wr && (i_reg == 2'd0);
  assign w_wr1 = i_wr && (i_reg == 2'd1);
  assign w_wr2 = i_wr && (i_reg == 2'd2);
  assign w_wr3 = i_wr && (i_reg == 2'd3);
  assign w_sw_upd = i_hlf && (r_sw_div == 3'd0) && r_r1[7] && (r_r1[2:0] != 3'd0) && !w_mute;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_r0 <= '0; r_r1 <= '0; r_r2 <= '0; r_per_hi <= '0;
      r_timer <= '0; r_seq <= '0;
      r_env_start <= 1'b0; r_decay <= '0; r_env_div <= '0;
      r_len <= '0; r_sw_div <= '0; r_sw_reload <= 1'b0; r_ch_out <= '0;
    end else begin
      // Sweep write-back first so a same-edge CPU write overrides it.
      if (w_sw_upd) begin
        r_r2     <= w_target[7:0];
        r_per_hi <= w_target[10:8];
      end
      if (w_wr0) r_r0 <= i_data;
      if (w_wr1) r_r1 <= i_data;
      if (w_wr2) r_r2 <= i_data;
      if (w_wr3) r_per_hi <= i_data[2:0];

      if (i_tick) begin
        if (r_timer == 11'd0) begin
          r_timer <= w_period;
          r_seq   <= r_seq + 3'd1;
        end else r_timer <= r_timer - 11'd1;
      end
      if (w_wr3) r_seq <= 3'd0;

      if (i_qtr) begin
        if (r_env_start) begin
          r_env_start <= 1'b0;
          r_decay     <= 4'd15;
          r_env_div   <= r_r0[3:0];
        end else if (r_env_div == 4'd0) begin
          r_env_div <= r_r0[3:0];
          if (r_decay != 4'd0) r_decay <= r_decay - 4'd1;
          else if (r_r0[5])    r_decay <= 4'd15;
        end else r_env_div <= r_env_div - 4'd1;
      end
      if (w_wr3) r_env_start <= 1'b1;

      if (!i_en)                                      r_len <= 8'd0;
      else if (w_wr3)                                 r_len <= w_lut;
      else if (i_hlf && (r_len != 8'd0) && !r_r0[5])  r_len <= r_len - 8'd1;

      if (i_hlf) begin
        if ((r_sw_div == 3'd0) || r_sw_reload) begin
          r_sw_div    <= r_r1[6:4];
          r_sw_reload <= 1'b0;
        end else r_sw_div <= r_sw_div - 3'd1;
      end
      if (w_wr1) r_sw_reload <= 1'b1;

      r_ch_out <= o_vol_nxt;
    end
  end
endmodule

module pulse_bank #(
  parameter int N_CH = 2,
  parameter int CW   = (N_CH > 2) ? $clog2(N_CH) : 1,
  parameter int MW   = 4 + CW
) (
  input  logic              apu_clk,
  input  logic              rst_n,
  input  logic              tick_en,
  input  logic              qtr_en,
  input  logic              hlf_en,
  input  logic              wr_en,
  input  logic [CW+1:0]     wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [N_CH-1:0]   ch_enable,
  output logic [N_CH-1:0]   len_active,
  output logic [4*N_CH-1:0] ch_out,
  output logic [MW-1:0]     mix_out
);
  logic [N_CH-1:0][3:0] w_vol_nxt;
  logic [MW-1:0]        w_mix, r_mix;

  // Channel selects with no matching voice simply enable nothing.
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic w_sel;
    assign w_sel = wr_en && (wr_addr[CW+1:2] == CW'(k));
    pulse_bank_ch #(.CH_IDX(k)) u_ch (
      .i_clk(apu_clk), .i_rst_n(rst_n), .i_tick(tick_en), .i_qtr(qtr_en), .i_hlf(hlf_en),
      .i_wr(w_sel), .i_reg(wr_addr[1:0]), .i_data(wr_data), .i_en(ch_enable[k]),
      .o_len_active(len_active[k]), .o_vol_nxt(w_vol_nxt[k]), .o_ch_out(ch_out[4*k +: 4])
    );
  end

  always_comb begin
    w_mix = '0;
    for (int k = 0; k < N_CH; k++) w_mix = w_mix + MW'(w_vol_nxt[k]);
  end

  always_ff @(posedge apu_clk) begin
    if (!rst_n) r_mix <= '0;
    else        r_mix <= w_mix;
  end

  assign mix_out = r_mix;
endmodule
